// File: rtl/sram_cache_dm.sv
// Direct-mapped write-through cache in front of sram_ctrl; read hit 2 cycles, miss/write 2 + memory cycles.
// Backpressure: s_wait stays high until completion and m_wait stalls the memory access; SRAM_CACHE_FLUSH_EN adds runtime flush.
module sram_cache_dm #(
    parameter int ADDR_W = 17,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [31:0]       s_wrdata,
    input  logic [3:0]        s_bytesel,
    input  logic              s_wren,
    input  logic              s_strobe,
    output logic              s_wait,
    output logic [31:0]       s_rddata,
`ifdef SRAM_CACHE_FLUSH_EN
    input  logic              flush,
`endif
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wrdata,
    output logic [3:0]        m_bytesel,
    output logic              m_wren,
    output logic              m_strobe,
    input  logic              m_wait,
    input  logic [31:0]       m_rddata
);

    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_RD,
        ST_MEM_WR
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      data_mem [LINES];
    logic [TAG_W:0]   tag_mem  [LINES];
    logic [31:0]      data_q;
    logic [TAG_W:0]   tag_q;

    logic [IDX_W-1:0] s_idx;
    logic [TAG_W-1:0] s_tag;
    logic [IDX_W-1:0] init_cnt;
    logic             hit;
    logic             hit_q, hit_d;
    logic [31:0]      merged;

    logic             tag_we;
    logic [IDX_W-1:0] tag_widx;
    logic [TAG_W:0]   tag_wdat;
    logic             data_we;
    logic [31:0]      data_wdat;

    logic [ADDR_W-1:0] m_addr_d;
    logic [31:0]       m_wrdata_d;
    logic [3:0]        m_bytesel_d;
    logic              m_wren_d;
    logic              m_strobe_d;

`ifdef SRAM_CACHE_FLUSH_EN
    logic flush_pend;
    logic go_init;
`endif

    assign s_idx = s_addr[IDX_W-1:0];
    assign s_tag = s_addr[ADDR_W-1:IDX_W];
    assign hit   = tag_q[TAG_W] && (tag_q[TAG_W-1:0] == s_tag);

    // The master holds s_addr stable, so the RAMs simply track its index every cycle.
    always_ff @(posedge clk) begin
        data_q <= data_mem[s_idx];
        tag_q  <= tag_mem[s_idx];
        if (tag_we) begin
            tag_mem[tag_widx] <= tag_wdat;
        end
        if (data_we) begin
            data_mem[s_idx] <= data_wdat;
        end
    end

    always_comb begin
        merged = data_q;
        for (int b = 0; b < 4; b++) begin
            if (s_bytesel[b]) begin
                merged[8*b +: 8] = s_wrdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        s_wait      = 1'b1;
        s_rddata    = '0;
        hit_d       = hit_q;
        tag_we      = 1'b0;
        tag_widx    = s_idx;
        tag_wdat    = '0;
        data_we     = 1'b0;
        data_wdat   = m_rddata;
        m_addr_d    = m_addr;
        m_wrdata_d  = m_wrdata;
        m_bytesel_d = m_bytesel;
        m_wren_d    = m_wren;
        m_strobe_d  = m_strobe;
`ifdef SRAM_CACHE_FLUSH_EN
        go_init     = 1'b0;
`endif
        case (state_q)
            ST_INIT: begin
                tag_we   = ~reset;
                tag_widx = init_cnt;
                if (init_cnt == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
`ifdef SRAM_CACHE_FLUSH_EN
                if (flush_pend) begin
                    go_init = 1'b1;
                    state_d = ST_INIT;
                end else if (s_strobe) begin
                    state_d = ST_LOOKUP;
                end
`else
                if (s_strobe) begin
                    state_d = ST_LOOKUP;
                end
`endif
            end
            ST_LOOKUP: begin
                hit_d = hit;
                if (!s_wren) begin
                    if (hit) begin
                        s_wait   = 1'b0;
                        s_rddata = data_q;
                        state_d  = ST_IDLE;
                    end else begin
                        m_addr_d    = s_addr;
                        m_wren_d    = 1'b0;
                        m_bytesel_d = 4'b1111;
                        m_strobe_d  = 1'b1;
                        state_d     = ST_MEM_RD;
                    end
                end else begin
                    m_addr_d    = s_addr;
                    m_wrdata_d  = s_wrdata;
                    m_bytesel_d = s_bytesel;
                    m_wren_d    = 1'b1;
                    m_strobe_d  = 1'b1;
                    state_d     = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                if (!m_wait) begin
                    tag_we     = ~reset;
                    tag_wdat   = {1'b1, s_tag};
                    data_we    = ~reset;
                    data_wdat  = m_rddata;
                    s_wait     = 1'b0;
                    s_rddata   = m_rddata;
                    m_strobe_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_MEM_WR: begin
                if (!m_wait) begin
                    // Write-no-allocate: only a line that hit at lookup absorbs the new bytes.
                    data_we    = hit_q & ~reset;
                    data_wdat  = merged;
                    s_wait     = 1'b0;
                    m_strobe_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_INIT;
            init_cnt  <= '0;
            hit_q     <= 1'b0;
            m_addr    <= '0;
            m_wrdata  <= '0;
            m_bytesel <= '0;
            m_wren    <= 1'b0;
            m_strobe  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hit_q     <= hit_d;
            m_addr    <= m_addr_d;
            m_wrdata  <= m_wrdata_d;
            m_bytesel <= m_bytesel_d;
            m_wren    <= m_wren_d;
            m_strobe  <= m_strobe_d;
            // Wraps back to zero after the last line, ready for the next sweep.
            if (state_q == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

`ifdef SRAM_CACHE_FLUSH_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_pend <= 1'b0;
        end else begin
            flush_pend <= (flush_pend & ~go_init) | flush;
        end
    end
`endif

endmodule

// File: tb/tb_sram_cache_dm.sv
// Self-checking bench for sram_cache_dm: vector table, randomized traffic against a cache/memory model, reset and flush corners.
module tb_sram_cache_dm;
    localparam int ADDR_W = 17;
    localparam int IDX_W  = 8;
    localparam int TAG_W  = ADDR_W - IDX_W;
    localparam int NLINES = 1 << IDX_W;
    localparam int MEMW   = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0]       s_wrdata;
    logic [3:0]        s_bytesel;
    logic              s_wren;
    logic              s_strobe;
    logic              s_wait;
    logic [31:0]       s_rddata;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wrdata;
    logic [3:0]        m_bytesel;
    logic              m_wren;
    logic              m_strobe;
    logic              m_wait;
    logic [31:0]       m_rddata;
`ifdef SRAM_CACHE_FLUSH_EN
    logic              flush;
    int                flush_cyc;
`endif

    int checks   = 0;
    int failures = 0;

    sram_cache_dm #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .s_addr   (s_addr),
        .s_wrdata (s_wrdata),
        .s_bytesel(s_bytesel),
        .s_wren   (s_wren),
        .s_strobe (s_strobe),
        .s_wait   (s_wait),
        .s_rddata (s_rddata),
`ifdef SRAM_CACHE_FLUSH_EN
        .flush    (flush),
`endif
        .m_addr   (m_addr),
        .m_wrdata (m_wrdata),
        .m_bytesel(m_bytesel),
        .m_wren   (m_wren),
        .m_strobe (m_strobe),
        .m_wait   (m_wait),
        .m_rddata (m_rddata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        end
        return r;
    endfunction

    // Memory behind the cache, plus the model's view of what it should contain.
    logic [31:0]       sram    [MEMW];
    logic [31:0]       ref_mem [MEMW];
    int                mem_lat = 0;
    int                wcnt    = 0;
    int                mem_ops = 0;
    logic [3:0]        last_be;
    logic              last_wren;
    logic [ADDR_W-1:0] last_addr;

    initial begin
        m_wait   = 1'b1;
        m_rddata = '0;
        forever begin
            @(negedge clk);
            if (m_strobe && !reset) begin
                if (wcnt >= mem_lat) begin
                    m_wait    = 1'b0;
                    mem_ops++;
                    last_be   = m_bytesel;
                    last_wren = m_wren;
                    last_addr = m_addr;
                    if (m_wren) begin
                        sram[m_addr] = bmerge(sram[m_addr], m_wrdata, m_bytesel);
                        m_rddata     = $urandom;
                    end else begin
                        m_rddata = sram[m_addr];
                    end
                end else begin
                    m_wait   = 1'b1;
                    wcnt++;
                    m_rddata = $urandom;
                end
            end else begin
                m_wait   = 1'b1;
                wcnt     = 0;
                m_rddata = $urandom;
            end
        end
    end

    // Reference cache: one valid/tag/word per index, filled on read miss only.
    logic             mv [NLINES];
    logic [TAG_W-1:0] mt [NLINES];
    logic [31:0]      md [NLINES];

    task automatic model_invalidate();
        for (int i = 0; i < NLINES; i++) mv[i] = 1'b0;
    endtask

    task automatic model_access(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                                input logic [3:0] be, output logic hit, output logic [31:0] rd);
        int idx;
        int tg;
        idx = int'(a) % NLINES;
        tg  = int'(a) / NLINES;
        hit = mv[idx] && (mt[idx] == TAG_W'(tg));
        rd  = '0;
        if (wr) begin
            ref_mem[a] = bmerge(ref_mem[a], d, be);
            if (hit) md[idx] = bmerge(md[idx], d, be);
        end else if (hit) begin
            rd = md[idx];
        end else begin
            rd      = ref_mem[a];
            mv[idx] = 1'b1;
            mt[idx] = TAG_W'(tg);
            md[idx] = rd;
        end
    endtask

    task automatic do_access(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                             input logic [3:0] be, output logic [31:0] rd, output int lat,
                             output int ops, output logic iz);
        int   cyc;
        int   ops0;
        logic done;
        cyc  = 0;
        ops0 = mem_ops;
        done = 1'b0;
        rd   = '0;
        iz   = 1'b1;
        s_wren    = wr;
        s_addr    = a;
        s_wrdata  = d;
        s_bytesel = be;
        s_strobe  = 1'b1;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            cyc++;
`ifdef SRAM_CACHE_FLUSH_EN
            #1 flush = (cyc == flush_cyc);
`endif
            @(negedge clk);
            #1;
            if (!s_wait) begin
                done = 1'b1;
                rd   = s_rddata;
            end else if (s_rddata != 32'h0) begin
                iz = 1'b0;
            end
        end
        lat = done ? cyc + 1 : -1;
        @(posedge clk);
        #1;
        s_strobe = 1'b0;
`ifdef SRAM_CACHE_FLUSH_EN
        flush = 1'b0;
`endif
        ops = mem_ops - ops0;
    endtask

    task automatic run_one(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                           input logic [3:0] be, input int ml, output logic [31:0] rd, output int ops);
        logic        hit;
        logic [31:0] erd;
        int          lat;
        logic        iz;
        mem_lat = ml;
        model_access(wr, a, d, be, hit, erd);
        do_access(wr, a, d, be, rd, lat, ops, iz);
        chk("rddata", 64'(rd), 64'(erd));
        chk("latency", 64'(lat), 64'((!wr && hit) ? 2 : 3 + ml));
        chk("mem_ops", 64'(ops), 64'((!wr && hit) ? 0 : 1));
        chk("rddata_zero_while_waiting", 64'(iz), 64'(1));
        if (ops == 1) begin
            chk("m_bytesel", 64'(last_be), 64'(wr ? be : 4'hf));
            chk("m_wren", 64'(last_wren), 64'(wr));
            chk("m_addr", 64'(last_addr), 64'(a));
        end
        if (wr) chk("mem_word", 64'(sram[a]), 64'(ref_mem[a]));
    endtask

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wd;
        logic [3:0]        be;
        logic [31:0]       exp_rd;
        int                exp_ops;
    } vec_t;

    vec_t tab [13];

    initial begin
        logic [31:0] rd;
        int          ops;
        int          k;
        int          first;
        logic        early;
        logic        hit;
        logic [31:0] erd;
        int          lat;
        logic        iz;

        tab[0]  = '{1'b0, 17'h00001, 32'h0,        4'h0, 32'h11223344, 0};
        tab[1]  = '{1'b1, 17'h00001, 32'hAABBCCDD, 4'h4, 32'h0,        1};
        tab[2]  = '{1'b0, 17'h00001, 32'h0,        4'h0, 32'h11BB3344, 0};
        tab[3]  = '{1'b1, 17'h10000, 32'hDEADBEEF, 4'hF, 32'h0,        1};
        tab[4]  = '{1'b0, 17'h10000, 32'h0,        4'h0, 32'hDEADBEEF, 1};
        tab[5]  = '{1'b0, 17'h10000, 32'h0,        4'h0, 32'hDEADBEEF, 0};
        tab[6]  = '{1'b0, 17'h00002, 32'h0,        4'h0, 32'hA0A00002, 1};
        tab[7]  = '{1'b0, 17'h10002, 32'h0,        4'h0, 32'hB0B00002, 1};
        tab[8]  = '{1'b0, 17'h00002, 32'h0,        4'h0, 32'hA0A00002, 1};
        tab[9]  = '{1'b1, 17'h00002, 32'h12345678, 4'h0, 32'h0,        1};
        tab[10] = '{1'b0, 17'h00002, 32'h0,        4'h0, 32'hA0A00002, 0};
        tab[11] = '{1'b0, 17'h1FFFF, 32'h0,        4'h0, 32'hCAFEF00D, 1};
        tab[12] = '{1'b0, 17'h1FFFF, 32'h0,        4'h0, 32'hCAFEF00D, 0};

        for (int i = 0; i < MEMW; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        sram[17'h00001] = 32'h11223344;
        sram[17'h00002] = 32'hA0A00002;
        sram[17'h10002] = 32'hB0B00002;
        sram[17'h10000] = 32'h55555555;
        sram[17'h1FFFF] = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            logic [ADDR_W-1:0] pa;
            case (i)
                0: pa = 17'h00001;
                1: pa = 17'h00002;
                2: pa = 17'h10002;
                3: pa = 17'h10000;
                default: pa = 17'h1FFFF;
            endcase
            ref_mem[pa] = sram[pa];
        end
        model_invalidate();

`ifdef SRAM_CACHE_FLUSH_EN
        flush     = 1'b0;
        flush_cyc = 0;
`endif
        reset     = 1'b1;
        s_strobe  = 1'b1;
        s_wren    = 1'b0;
        s_addr    = 17'h00001;
        s_wrdata  = '0;
        s_bytesel = '0;
        mem_lat   = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_s_wait", 64'(s_wait), 64'(1));
        chk("reset_s_rddata", 64'(s_rddata), 64'(0));
        chk("reset_m_strobe", 64'(m_strobe), 64'(0));
        chk("reset_m_wren", 64'(m_wren), 64'(0));
        chk("reset_m_addr", 64'(m_addr), 64'(0));
        chk("reset_m_wrdata", 64'(m_wrdata), 64'(0));
        chk("reset_m_bytesel", 64'(m_bytesel), 64'(0));

        // Request held through the init sweep: memory must see nothing until it ends.
        @(posedge clk);
        #1 reset = 1'b0;
        k     = 0;
        first = -1;
        early = 1'b0;
        while (first < 0 && k < 1000) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            #1;
            if (m_strobe) first = k;
            else if (!s_wait) early = 1'b1;
        end
        chk("init_first_m_strobe_edge", 64'(first), 64'(NLINES + 2));
        chk("init_no_early_completion", 64'(early), 64'(0));
        chk("init_read_done", 64'(s_wait), 64'(0));
        chk("init_read_data", 64'(s_rddata), 64'(32'h11223344));
        @(posedge clk);
        #1 s_strobe = 1'b0;
        model_access(1'b0, 17'h00001, 32'h0, 4'h0, hit, erd);

        for (int i = 0; i < 13; i++) begin
            run_one(tab[i].wr, tab[i].addr, tab[i].wd, tab[i].be, i % 3, rd, ops);
            chk("tab_rddata", 64'(rd), 64'(tab[i].exp_rd));
            chk("tab_mem_ops", 64'(ops), 64'(tab[i].exp_ops));
        end
        chk("tab_merged_mem_word", 64'(sram[17'h00001]), 64'(32'h11BB3344));

        // Reset in the middle of a memory read aborts it and re-runs the sweep.
        mem_lat  = 30;
        s_wren   = 1'b0;
        s_addr   = 17'h00007;
        s_strobe = 1'b1;
        k        = 0;
        first    = -1;
        while (first < 0 && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            #1;
            if (m_strobe) first = k;
        end
        chk("abort_m_strobe_seen", 64'(first), 64'(2));
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        s_strobe = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_m_strobe_low", 64'(m_strobe), 64'(0));
        chk("abort_s_wait_high", 64'(s_wait), 64'(1));
        repeat (300) @(posedge clk);
        #1;
        model_invalidate();
        run_one(1'b0, 17'h00001, 32'h0, 4'h0, 1, rd, ops);

        for (int i = 0; i < 300; i++) begin
            logic              wr;
            logic [ADDR_W-1:0] a;
            logic [TAG_W-1:0]  tg;
            int                ts;
            wr = ($urandom_range(0, 2) == 0);
            ts = $urandom_range(0, 2);
            tg = (ts == 0) ? TAG_W'(0) : (ts == 1) ? TAG_W'(1) : TAG_W'(9'h1FF);
            a  = {tg, IDX_W'($urandom_range(0, 7))};
            run_one(wr, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), rd, ops);
        end

`ifdef SRAM_CACHE_FLUSH_EN
        run_one(1'b0, 17'h00001, 32'h0, 4'h0, 0, rd, ops);
        run_one(1'b0, 17'h00001, 32'h0, 4'h0, 0, rd, ops);
        flush_cyc = 2;
        run_one(1'b0, 17'h00003, 32'h0, 4'h0, 3, rd, ops);
        flush_cyc = 0;
        model_invalidate();
        mem_lat = 1;
        model_access(1'b0, 17'h00001, 32'h0, 4'h0, hit, erd);
        do_access(1'b0, 17'h00001, 32'h0, 4'h0, rd, lat, ops, iz);
        chk("flush_read_data", 64'(rd), 64'(erd));
        chk("flush_read_latency", 64'(lat), 64'(NLINES + 4 + 1));
        chk("flush_read_mem_ops", 64'(ops), 64'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
